mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle sequencer for the MIPS datapath. One instruction runs as a sequence of states over shared ALU and unified memory.
- Decodes Opcode/Func from the instruction register and drives all datapath enables and mux selects each cycle.
- Waits on a memory ready handshake and applies a wait-timeout watchdog.
- Sits beside the register file, ALU and memory, replacing the single-cycle combinational control decode.

Parameters:
- MAX_WAIT, 15: max consecutive cycles waiting on mem_ready before abort; legal range 1..255.
- WAIT_W, 8: width of the internal wait counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- Opcode  input  6  IR[31:26].
- Func  input  6  IR[5:0].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  output  1  write-back source: 0 = ALUOut, 1 = data register.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B select: 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCWrite  output  1  PC load enable (already gated for branch).
- state  output  4  current state code, for debug.
- illegal_op  output  1  one-cycle pulse on unsupported opcode or Func.
- mem_timeout  output  1  one-cycle pulse when the watchdog aborts.

Behaviour:
- Reset: one clock and a synchronous, active-high reset. RST high at a rising CLK edge puts the FSM in FETCH with wait counter = 0. RST has priority over everything, including a mid-instruction reset (no RegWrite/MemWrite in the reset cycle).
- Output reset values: state = FETCH. In FETCH with mem_ready = 0: MemRead = 1, ALUSrcB = 01, ALUControl = 010, all other outputs 0.
- State codes: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXECUTE, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP. Codes 12-15 go to FETCH on the next clock.
- Output model: Moore outputs from state, except:
  - IRWrite and PCWrite in FETCH are qualified by mem_ready.
  - BRANCH PCWrite = Zero.
  - EXECUTE ALUControl is decoded from Func.
- Unlisted outputs are 0; ALUControl defaults to 010.
- Per-state outputs:
  - FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, PCSrc = 00. IRWrite and PCWrite = mem_ready. Exit to DECODE when mem_ready.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11. Next state by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - Any other opcode -> FETCH, with illegal_op pulsed in this cycle.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10. Next: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: IorD = 1, MemRead = 1. Exit to MEMWB when mem_ready.
  - MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1. Next: FETCH.
  - MEMWRITE: IorD = 1, MemWrite = 1, held until mem_ready. Exit to FETCH when mem_ready.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00.
    - Func decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
    - Supported Func -> ALUWB.
    - Any other Func -> FETCH, illegal_op pulsed, no write-back.
  - ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1. Next: FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 110, PCSrc = 01, PCWrite = Zero. Next: FETCH.
  - ADDIEX: ALUSrcA = 1, ALUSrcB = 10. Next: ADDIWB.
  - ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. Next: FETCH.
  - JUMP: PCSrc = 10, PCWrite = 1. Next: FETCH.
- Instruction latency (FETCH counted as 1 cycle with zero memory wait):
  - lw = 5, sw = 4, R-type = 4, addi = 4, beq = 3, j = 3.
  - Each memory wait cycle adds 1.
- Watchdog, applies in FETCH, MEMREAD and MEMWRITE:
  - The wait counter increments on each cycle with mem_ready = 0 and clears on any state change or on mem_ready = 1.
  - When the counter equals MAX_WAIT and mem_ready = 0, mem_timeout pulses for that cycle and the next state is FETCH with the counter cleared. In FETCH this is a re-fetch.
  - The aborted instruction produces no IRWrite, PCWrite, RegWrite or further MemWrite.
  - If mem_ready = 1 in the same cycle the count hits MAX_WAIT, ready wins: normal completion, no timeout.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined: adds output ports cycle_count (32 bits) and instr_count (32 bits), both 0 on reset.
  - cycle_count increments every cycle RST is low.
  - instr_count increments each cycle where FETCH && mem_ready.
  - Both counters wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- RST = 1 for 2 cycles, mem_ready = 1 -> state = 0, RegWrite = MemWrite = PCWrite = 0 during reset; first post-reset cycle IRWrite = PCWrite = 1.
- lw (Opcode 100011), mem_ready = 1 -> states 0, 1, 2, 3, 4, 0; RegWrite = 1 only in state 4, MemtoReg = 1; 5 cycles.
- R-type sub (Func 100010) -> ALUControl = 110 in EXECUTE; RegDst = 1, RegWrite = 1 in ALUWB. Repeat with Func 000000 -> illegal_op pulse, back to FETCH, no RegWrite.
- beq with Zero = 1, then Zero = 0 -> PCWrite = 1 / 0 in BRANCH, PCSrc = 01 in both.
- sw with mem_ready low 3 cycles then high -> MemWrite held 4 cycles, single exit to FETCH. Same with mem_ready low 16 cycles (MAX_WAIT = 15) -> mem_timeout pulse at cycle 16, state = FETCH.
- With MC_CTRL_PERF_CNT_EN: run j, addi, lw (no waits) -> instr_count = 3, cycle_count = 12.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer with a memory-ready watchdog.
// Optional performance counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              wait_hit;
    logic              in_wait_state;

    assign state         = cur_state;
    assign wait_hit      = (wait_cnt == MAX_WAIT_C) && !mem_ready;
    assign in_wait_state = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                           (cur_state == S_MEMWRITE);

    // Counter runs only while a memory state keeps waiting; any exit, ready or abort clears it.
    assign wait_cnt_nxt = (in_wait_state && !mem_ready && !wait_hit && (nxt_state == cur_state))
                          ? wait_cnt + 1'b1 : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

    always_comb begin
        nxt_state   = S_FETCH;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        PCSrc       = 2'b00;
        PCWrite     = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end else begin
                    mem_timeout = wait_hit;
                    nxt_state   = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEMWB;
                end else if (wait_hit) begin
                    mem_timeout = 1'b1;
                    nxt_state   = S_FETCH;
                end else begin
                    nxt_state = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                end else if (wait_hit) begin
                    mem_timeout = 1'b1;
                    nxt_state   = S_FETCH;
                end else begin
                    nxt_state = S_MEMWRITE;
                end
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                nxt_state = S_ALUWB;
                case (Func)
                    FN_ADD: ALUControl = ALU_ADD;
                    FN_SUB: ALUControl = ALU_SUB;
                    FN_AND: ALUControl = ALU_AND;
                    FN_OR:  ALUControl = ALU_OR;
                    FN_SLT: ALUControl = ALU_SLT;
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = Zero;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase

        // A reset cycle must not commit any architectural side effect, even mid-instruction.
        if (RST) begin
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if ((cur_state == S_FETCH) && mem_ready) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule
